// File: rtl/wb_ram_pkg.sv
// Shared constants and FSM state type for the banked Wishbone RAM.
package wb_ram_pkg;

  localparam int unsigned BANK_DEPTH = 512;
  localparam int unsigned BANK_AW    = 9;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/ram512x32.sv
// Behavioural model of the 512x32 single-port SRAM macro.
// cen_i is active-low; wen_i holds active-low byte write enables.
// With all wen_i bits high an enabled access is a read, data valid next cycle.
module ram512x32 (
`ifdef USE_POWER_PINS
  inout  wire         vccd1,
  inout  wire         vssd1,
`endif
  input  logic        clk_i,
  input  logic        cen_i,
  input  logic [3:0]  wen_i,
  input  logic [8:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o
);

  logic [31:0] mem [512];

  // Byte-masked write or synchronous read on an enabled cycle.
  always_ff @(posedge clk_i) begin
    if (!cen_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!wen_i[i]) mem[adr_i][8*i +: 8] <= dat_i[8*i +: 8];
      end
      if (&wen_i) dat_o <= mem[adr_i];
    end
  end

endmodule

// File: rtl/wb_ram_bank.sv
// One 512-word bank: converts the bank enable and byte selects into the
// macro's active-low controls and wraps the macro with its supply pins.
module wb_ram_bank
  import wb_ram_pkg::*;
(
`ifdef USE_POWER_PINS
  inout  wire                vccd1,
  inout  wire                vssd1,
`endif
  input  logic               clk_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [3:0]         sel_i,
  input  logic [BANK_AW-1:0] adr_i,
  input  logic [DATA_W-1:0]  dat_i,
  output logic [DATA_W-1:0]  dat_o,
  output logic               cen_o
);

  logic       cen_n;
  logic [3:0] wen_n;

  // Enable is only ever asserted for the accept cycle; a write with no byte
  // lanes set degenerates to a harmless read.
  always_comb begin
    cen_n = ~en_i;
    wen_n = (en_i && we_i) ? ~sel_i : '1;
  end

  assign cen_o = cen_n;

  ram512x32 u_ram (
`ifdef USE_POWER_PINS
    .vccd1 (vccd1),
    .vssd1 (vssd1),
`endif
    .clk_i (clk_i),
    .cen_i (cen_n),
    .wen_i (wen_n),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .dat_o (dat_o)
  );

endmodule

// File: rtl/wb_ram_banked.sv
// Wishbone slave RAM built from DEPTH/512 SRAM macro banks.
// One termination per accepted request; optional read-data output register;
// out-of-range accesses either error-terminate or alias modulo bank count.
module wb_ram_banked
  import wb_ram_pkg::*;
#(
  parameter  int unsigned DEPTH   = 2048,
  parameter  int unsigned OUT_REG = 0,
  parameter  int unsigned ERR_EN  = 1,
  localparam int unsigned ADR_W   = $clog2(DEPTH)
) (
`ifdef USE_POWER_PINS
  inout  wire               vccd1,
  inout  wire               vssd1,
`endif
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [ADR_W-1:0]  wb_adr_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o
);

  localparam int unsigned NR_BANKS = DEPTH / BANK_DEPTH;
  localparam int unsigned BSEL_W   = (NR_BANKS > 1) ? $clog2(NR_BANKS) : 1;

  state_t              state_q, state_d;
  logic                accept;
  logic [ADR_W:0]      adr_ext;
  logic [ADR_W:0]      bank_raw;
  logic [ADR_W:0]      bank_alias;
  logic                in_range;
  logic                addr_err;
  logic [BSEL_W-1:0]   bank_idx;
  logic [BSEL_W-1:0]   bank_q;
  logic                err_q;
  logic                we_q;
  logic [DATA_W-1:0]   rd_mux;
  logic [DATA_W-1:0]   rd_q;
  logic [NR_BANKS-1:0] bank_en;
  logic [NR_BANKS-1:0] bank_cen_n;
  logic [DATA_W-1:0]   bank_dout [NR_BANKS];

  // Address decode: unused select codes (non power-of-two bank count) fall
  // outside DEPTH, so one range compare covers both error sources. Taking the
  // select modulo NR_BANKS is an identity for in-range addresses and gives the
  // aliasing behaviour when errors are disabled.
  always_comb begin
    adr_ext    = {1'b0, wb_adr_i};
    in_range   = adr_ext < (ADR_W+1)'(DEPTH);
    bank_raw   = adr_ext >> BANK_AW;
    bank_alias = bank_raw % (ADR_W+1)'(NR_BANKS);
    bank_idx   = BSEL_W'(bank_alias);
    addr_err   = (ERR_EN != 0) && !in_range;
  end

  // Next-state logic; accept is only possible from IDLE and never in reset.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          accept = 1'b1;
          if (addr_err || wb_we_i || (OUT_REG == 0)) state_d = RESP;
          else                                       state_d = WAIT;
        end
      end
      WAIT:    state_d = wb_cyc_i ? RESP : IDLE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      accept  = 1'b0;
      state_d = IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture request attributes at accept so the response ignores live inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q <= '0;
      err_q  <= 1'b0;
      we_q   <= 1'b0;
    end else if (accept) begin
      bank_q <= bank_idx;
      err_q  <= addr_err;
      we_q   <= wb_we_i;
    end
  end

  // Per-bank enable: only the addressed bank, only in the accept cycle.
  always_comb begin
    bank_en = '0;
    for (int unsigned b = 0; b < NR_BANKS; b++) begin
      bank_en[b] = accept && !addr_err && (bank_idx == BSEL_W'(b));
    end
  end

  for (genvar g = 0; g < NR_BANKS; g++) begin : g_bank
    wb_ram_bank u_bank (
`ifdef USE_POWER_PINS
      .vccd1 (vccd1),
      .vssd1 (vssd1),
`endif
      .clk_i (clk_i),
      .en_i  (bank_en[g]),
      .we_i  (wb_we_i),
      .sel_i (wb_sel_i),
      .adr_i (wb_adr_i[BANK_AW-1:0]),
      .dat_i (wb_dat_i),
      .dat_o (bank_dout[g]),
      .cen_o (bank_cen_n[g])
    );
  end

  // Read mux driven by the registered bank select.
  always_comb begin
    rd_mux = '0;
    for (int unsigned b = 0; b < NR_BANKS; b++) begin
      if (bank_q == BSEL_W'(b)) rd_mux = bank_dout[b];
    end
  end

  // Optional output register, loaded in the WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i)                rd_q <= '0;
    else if (state_q == WAIT) rd_q <= rd_mux;
  end

  // Terminations are masked by reset so a pending response is dropped.
  always_comb begin
    wb_ack_o = (state_q == RESP) && !err_q && !rst_i;
    wb_err_o = (state_q == RESP) &&  err_q && !rst_i;
    wb_dat_o = '0;
    if (wb_ack_o && !we_q) wb_dat_o = (OUT_REG != 0) ? rd_q : rd_mux;
  end

endmodule

// File: tb/tb_wb_ram_banked.sv
// Directed bench for wb_ram_banked: three 1536-word instances
// (u0 plain, u1 with output register, u2 with aliasing instead of errors).
module tb_wb_ram_banked;

  localparam int unsigned AW = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cyc, stb, we;
  logic [3:0]  sel  [3];
  logic [AW-1:0] adr [3];
  logic [31:0] wdat [3];
  wire  [2:0]  ack, err;
  wire  [31:0] rdat [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_ram_banked #(.DEPTH(1536), .OUT_REG(0), .ERR_EN(1)) u0 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]), .wb_adr_i(adr[0]),
    .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]));

  wb_ram_banked #(.DEPTH(1536), .OUT_REG(1), .ERR_EN(1)) u1 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]), .wb_adr_i(adr[1]),
    .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]));

  wb_ram_banked #(.DEPTH(1536), .OUT_REG(0), .ERR_EN(0)) u2 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
    .wb_sel_i(sel[2]), .wb_dat_i(wdat[2]), .wb_adr_i(adr[2]),
    .wb_dat_o(rdat[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]));

  typedef struct {
    int          d;
    logic        we;
    logic [3:0]  sel;
    logic [10:0] adr;
    logic [31:0] wd;
    logic        is_err;
    logic [31:0] rd;
    int          lat;
    logic [2:0]  cen;
  } vec_t;

  vec_t vt [19];

  function automatic vec_t mk(input int d, input logic w, input logic [3:0] s,
                              input logic [10:0] a, input logic [31:0] wd,
                              input logic e, input logic [31:0] rd,
                              input int lat, input logic [2:0] cen);
    vec_t v;
    v.d = d; v.we = w; v.sel = s; v.adr = a; v.wd = wd;
    v.is_err = e; v.rd = rd; v.lat = lat; v.cen = cen;
    return v;
  endfunction

  function automatic logic [2:0] cen_of(input int d);
    case (d)
      0:       return u0.bank_cen_n;
      1:       return u1.bank_cen_n;
      default: return u2.bank_cen_n;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic c, input logic s, input logic w,
                       input logic [3:0] bs, input logic [10:0] a, input logic [31:0] wd);
    cyc[d] = c; stb[d] = s; we[d] = w; sel[d] = bs; adr[d] = a; wdat[d] = wd;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    bit got;
    got = 0;
    next_cycle();
    drive(v.d, 1'b1, 1'b1, v.we, v.sel, v.adr, v.wd);
    @(negedge clk);
    chk({tag, " accept cen"}, 32'(cen_of(v.d)), 32'(v.cen));
    next_cycle();
    stb[v.d] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) next_cycle();
      @(negedge clk);
      if (ack[v.d] || err[v.d]) begin
        got = 1;
        chk({tag, " latency"}, 32'(k), 32'(v.lat));
        chk({tag, " ack"}, 32'(ack[v.d]), 32'(!v.is_err));
        chk({tag, " err"}, 32'(err[v.d]), 32'(v.is_err));
        chk({tag, " data"}, rdat[v.d], (v.we || v.is_err) ? 32'h0 : v.rd);
        chk({tag, " idle cen"}, 32'(cen_of(v.d)), 32'h7);
        break;
      end
    end
    if (!got) chk({tag, " timeout"}, 32'h0, 32'h1);
    next_cycle();
    cyc[v.d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);

    vt[0]  = mk(0, 1'b1, 4'hF, 11'h000, 32'hDEADBEEF, 1'b0, 32'h0,        1, 3'b110);
    vt[1]  = mk(0, 1'b1, 4'hF, 11'h5FF, 32'hDEADBEEF, 1'b0, 32'h0,        1, 3'b011);
    vt[2]  = mk(0, 1'b0, 4'h0, 11'h000, 32'h0,        1'b0, 32'hDEADBEEF, 1, 3'b110);
    vt[3]  = mk(0, 1'b0, 4'h0, 11'h5FF, 32'h0,        1'b0, 32'hDEADBEEF, 1, 3'b011);
    vt[4]  = mk(0, 1'b1, 4'hF, 11'h200, 32'h11223344, 1'b0, 32'h0,        1, 3'b101);
    vt[5]  = mk(0, 1'b1, 4'h5, 11'h200, 32'hAABBCCDD, 1'b0, 32'h0,        1, 3'b101);
    vt[6]  = mk(0, 1'b0, 4'h0, 11'h200, 32'h0,        1'b0, 32'h11BB33DD, 1, 3'b101);
    vt[7]  = mk(0, 1'b1, 4'hF, 11'h201, 32'h11223344, 1'b0, 32'h0,        1, 3'b101);
    vt[8]  = mk(0, 1'b1, 4'h0, 11'h201, 32'hAABBCCDD, 1'b0, 32'h0,        1, 3'b101);
    vt[9]  = mk(0, 1'b0, 4'h0, 11'h201, 32'h0,        1'b0, 32'h11223344, 1, 3'b101);
    vt[10] = mk(0, 1'b0, 4'h0, 11'h600, 32'h0,        1'b1, 32'h0,        1, 3'b111);
    vt[11] = mk(0, 1'b1, 4'hF, 11'h7FF, 32'h01020304, 1'b1, 32'h0,        1, 3'b111);
    vt[12] = mk(1, 1'b1, 4'hF, 11'h3FF, 32'h12345678, 1'b0, 32'h0,        1, 3'b101);
    vt[13] = mk(1, 1'b0, 4'h0, 11'h3FF, 32'h0,        1'b0, 32'h12345678, 2, 3'b101);
    vt[14] = mk(1, 1'b0, 4'h0, 11'h600, 32'h0,        1'b1, 32'h0,        1, 3'b111);
    vt[15] = mk(2, 1'b1, 4'hF, 11'h000, 32'hCAFEF00D, 1'b0, 32'h0,        1, 3'b110);
    vt[16] = mk(2, 1'b0, 4'h0, 11'h600, 32'h0,        1'b0, 32'hCAFEF00D, 1, 3'b110);
    vt[17] = mk(2, 1'b1, 4'hF, 11'h7FF, 32'h0BADC0DE, 1'b0, 32'h0,        1, 3'b110);
    vt[18] = mk(2, 1'b0, 4'h0, 11'h1FF, 32'h0,        1'b0, 32'h0BADC0DE, 1, 3'b110);

    // Reset with requests asserted: reset must win.
    rst = 1'b1;
    for (int d = 0; d < 3; d++) drive(d, 1'b1, 1'b1, 1'b1, 4'hF, 11'h000, 32'h5555AAAA);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("reset u%0d ack", d), 32'(ack[d]), 32'h0);
        chk($sformatf("reset u%0d err", d), 32'(err[d]), 32'h0);
        chk($sformatf("reset u%0d dat", d), rdat[d], 32'h0);
        chk($sformatf("reset u%0d cen", d), 32'(cen_of(d)), 32'h7);
      end
      next_cycle();
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post-reset u%0d ack", d), 32'(ack[d]), 32'h0);
      chk($sformatf("post-reset u%0d err", d), 32'(err[d]), 32'h0);
      chk($sformatf("post-reset u%0d dat", d), rdat[d], 32'h0);
      chk($sformatf("post-reset u%0d cen", d), 32'(cen_of(d)), 32'h7);
    end

    for (int i = 0; i < 19; i++) run_txn(vt[i], $sformatf("vec%0d", i));

    // u1: strobe held six cycles -> terminations only on cycles 2 and 5.
    next_cycle();
    drive(1, 1'b1, 1'b1, 1'b0, 4'h0, 11'h3FF, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("held c%0d ack", k), 32'(ack[1]), 32'((k == 2) || (k == 5)));
      chk($sformatf("held c%0d dat", k), rdat[1], ((k == 2) || (k == 5)) ? 32'h12345678 : 32'h0);
      chk($sformatf("held c%0d cen", k), 32'(cen_of(1)), ((k == 0) || (k == 3)) ? 32'h5 : 32'h7);
      if (k < 5) next_cycle();
    end
    next_cycle();
    drive(1, 1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    @(negedge clk);
    chk("held after ack", 32'(ack[1]), 32'h0);

    // u1: reset in WAIT drops the read; the next read is still correct.
    next_cycle();
    drive(1, 1'b1, 1'b1, 1'b0, 4'h0, 11'h3FF, 32'h0);
    next_cycle();
    stb[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst-wait c1 term", 32'({ack[1], err[1]}), 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst-wait c2 term", 32'({ack[1], err[1]}), 32'h0);
    next_cycle();
    cyc[1] = 1'b0;
    @(negedge clk);
    chk("rst-wait c3 term", 32'({ack[1], err[1]}), 32'h0);
    run_txn(vt[13], "rst-wait reread");

    // u1: drop cyc in WAIT -> abort, IDLE next cycle (new request accepted).
    next_cycle();
    drive(1, 1'b1, 1'b1, 1'b0, 4'h0, 11'h3FF, 32'h0);
    next_cycle();
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    chk("abort c1 term", 32'({ack[1], err[1]}), 32'h0);
    next_cycle();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    @(negedge clk);
    chk("abort c2 term", 32'({ack[1], err[1]}), 32'h0);
    chk("abort c2 accept cen", 32'(cen_of(1)), 32'h5);
    next_cycle();
    stb[1] = 1'b0;
    @(negedge clk);
    chk("abort c3 term", 32'({ack[1], err[1]}), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("abort c4 ack", 32'(ack[1]), 32'h1);
    chk("abort c4 dat", rdat[1], 32'h12345678);
    next_cycle();
    cyc[1] = 1'b0;

    // u0: bank bits change during RESP -> data from the accepted bank.
    next_cycle();
    drive(0, 1'b1, 1'b1, 1'b0, 4'h0, 11'h000, 32'h0);
    next_cycle();
    stb[0] = 1'b0; adr[0] = 11'h200;
    @(negedge clk);
    chk("bank-hold ack", 32'(ack[0]), 32'h1);
    chk("bank-hold dat", rdat[0], 32'hDEADBEEF);
    next_cycle();
    cyc[0] = 1'b0;

    // u0: cyc low during RESP still terminates.
    next_cycle();
    drive(0, 1'b1, 1'b1, 1'b0, 4'h0, 11'h5FF, 32'h0);
    next_cycle();
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    chk("cyc-low-resp ack", 32'(ack[0]), 32'h1);
    chk("cyc-low-resp dat", rdat[0], 32'hDEADBEEF);

    // u0: reset in RESP of a write drops the ack but keeps the written data.
    next_cycle();
    drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 11'h201, 32'h5A5A5A5A);
    next_cycle();
    stb[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst-resp term", 32'({ack[0], err[0]}), 32'h0);
    next_cycle();
    rst = 1'b0;
    cyc[0] = 1'b0;
    run_txn(mk(0, 1'b0, 4'h0, 11'h201, 32'h0, 1'b0, 32'h5A5A5A5A, 1, 3'b101), "rst-resp reread");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
